// File: rtl/bist_session_if.sv
// Bundle of host-side and datapath-side signals for one LBIST session controller.
//   master : test host / datapath side (drives start, abort, TPG_END, ORA_RES)
//   slave  : bist_session_ctrl side (drives TPG/ORA enables, status and counters)
// Ports carried:
//   start, abort          host requests
//   TPG_END, ORA_RES      datapath status sampled during RUN
//   TPG_RESET, TPG_EN     TPG control
//   ORA_EN                ORA compare enable
//   busy, done, pass      session status / verdict
//   err_count, pat_count  session counters
interface bist_session_if #(
  parameter int ERR_BITS = 8,
  parameter int PAT_BITS = 16
);
  logic                start;
  logic                abort;
  logic                TPG_END;
  logic                ORA_RES;
  logic                TPG_RESET;
  logic                TPG_EN;
  logic                ORA_EN;
  logic                busy;
  logic                done;
  logic                pass;
  logic [ERR_BITS-1:0] err_count;
  logic [PAT_BITS-1:0] pat_count;

  modport master (
    output start, abort, TPG_END, ORA_RES,
    input  TPG_RESET, TPG_EN, ORA_EN, busy, done, pass, err_count, pat_count
  );

  modport slave (
    input  start, abort, TPG_END, ORA_RES,
    output TPG_RESET, TPG_EN, ORA_EN, busy, done, pass, err_count, pat_count
  );
endinterface

// File: rtl/bist_session_ctrl.sv
// LBIST session sequencer. Holds the TPG in reset for SETUP_CYCLES, applies patterns
// until TPG_END (or the error limit is crossed when STOP_ON_FAIL=1), counts patterns
// and ORA mismatches with saturating counters, and registers a pass/fail verdict.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    bist_session_if.slave (start/abort/TPG_END/ORA_RES in;
//          TPG_RESET/TPG_EN/ORA_EN/busy/done/pass/err_count/pat_count out)
//
// state | meaning
// IDLE  | waiting for start, TPG held in reset
// SETUP | TPG held in reset for SETUP_CYCLES cycles
// RUN   | one pattern applied and compared per cycle
// DONE  | verdict valid, counters frozen
module bist_session_ctrl #(
  parameter int ERR_BITS     = 8,
  parameter int PAT_BITS     = 16,
  parameter int SETUP_CYCLES = 3,
  parameter int ERR_LIMIT    = 0,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  bist_session_if.slave   bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int               SC_W       = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [SC_W-1:0]  SETUP_LAST = SC_W'(SETUP_CYCLES - 1);
  localparam logic [ERR_BITS-1:0] ERR_LIM = ERR_BITS'(ERR_LIMIT);

  logic [1:0]          state;
  logic [SC_W-1:0]     setup_cnt;
  logic [ERR_BITS-1:0] err_cnt;
  logic [PAT_BITS-1:0] pat_cnt;
  logic                pass_q;

  logic [ERR_BITS-1:0] err_nxt;
  logic [PAT_BITS-1:0] pat_nxt;
  logic                stop_hit;

  // Post-update counter values for the current RUN cycle; the verdict and the
  // early-stop decision both look at the count including this cycle's mismatch.
  always_comb begin
    pat_nxt = pat_cnt;
    err_nxt = err_cnt;
    if (pat_cnt != '1) pat_nxt = pat_cnt + PAT_BITS'(1);
    if (bus.ORA_RES && (err_cnt != '1)) err_nxt = err_cnt + ERR_BITS'(1);
    stop_hit = (STOP_ON_FAIL != 0) && (err_nxt > ERR_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      setup_cnt <= '0;
      err_cnt   <= '0;
      pat_cnt   <= '0;
      pass_q    <= 1'b0;
    end else if (bus.abort) begin
      // counters deliberately left as-is so the aborted session can be inspected
      state  <= IDLE;
      pass_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= SETUP;
            setup_cnt <= '0;
            err_cnt   <= '0;
            pat_cnt   <= '0;
            pass_q    <= 1'b0;
          end
        end
        SETUP: begin
          if (setup_cnt == SETUP_LAST) state <= RUN;
          else setup_cnt <= setup_cnt + SC_W'(1);
        end
        RUN: begin
          pat_cnt <= pat_nxt;
          err_cnt <= err_nxt;
          if (bus.TPG_END || stop_hit) begin
            state  <= DONE;
            pass_q <= (err_nxt <= ERR_LIM);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.TPG_RESET = (state != RUN);
  assign bus.TPG_EN    = (state == RUN);
  assign bus.ORA_EN    = (state == RUN);
  assign bus.busy      = (state == SETUP) || (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.pass      = pass_q;
  assign bus.err_count = err_cnt;
  assign bus.pat_count = pat_cnt;

endmodule

// File: tb/tb_bist_session_ctrl.sv
// Directed bench for bist_session_ctrl. Five instances with different parameter sets
// share one stimulus stream; each scenario checks the instance it targets.
module tb_bist_session_ctrl;
  logic clk;
  logic rst_n;
  logic start_s, abort_s, end_s, ora_s;

  int total = 0;
  int bad   = 0;

  bist_session_if                                  if_def ();
  bist_session_if                                  if_lim2 ();
  bist_session_if                                  if_lim1 ();
  bist_session_if                                  if_sof ();
  bist_session_if #(.ERR_BITS(2), .PAT_BITS(16))   if_sat ();

  assign if_def.start  = start_s;  assign if_def.abort  = abort_s;
  assign if_def.TPG_END = end_s;   assign if_def.ORA_RES = ora_s;
  assign if_lim2.start = start_s;  assign if_lim2.abort = abort_s;
  assign if_lim2.TPG_END = end_s;  assign if_lim2.ORA_RES = ora_s;
  assign if_lim1.start = start_s;  assign if_lim1.abort = abort_s;
  assign if_lim1.TPG_END = end_s;  assign if_lim1.ORA_RES = ora_s;
  assign if_sof.start  = start_s;  assign if_sof.abort  = abort_s;
  assign if_sof.TPG_END = end_s;   assign if_sof.ORA_RES = ora_s;
  assign if_sat.start  = start_s;  assign if_sat.abort  = abort_s;
  assign if_sat.TPG_END = end_s;   assign if_sat.ORA_RES = ora_s;

  bist_session_ctrl u_def (.clk(clk), .rst_n(rst_n), .bus(if_def));
  bist_session_ctrl #(.ERR_LIMIT(2)) u_lim2 (.clk(clk), .rst_n(rst_n), .bus(if_lim2));
  bist_session_ctrl #(.ERR_LIMIT(1)) u_lim1 (.clk(clk), .rst_n(rst_n), .bus(if_lim1));
  bist_session_ctrl #(.STOP_ON_FAIL(1)) u_sof (.clk(clk), .rst_n(rst_n), .bus(if_sof));
  bist_session_ctrl #(.ERR_BITS(2)) u_sat (.clk(clk), .rst_n(rst_n), .bus(if_sat));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // start sampled at the next edge; returns with the DUTs in their first RUN cycle
  task automatic start_session();
    start_s = 1'b1;
    step(1);
    start_s = 1'b0;
    step(3);
  endtask

  task automatic run_cycle(input logic ora, input logic fin);
    ora_s = ora;
    end_s = fin;
    step(1);
    ora_s = 1'b0;
    end_s = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_s = 1'b0; abort_s = 1'b0; end_s = 1'b0; ora_s = 1'b0;
    #3;
    check_val("rst_tpg_reset", if_def.TPG_RESET, 1);
    check_val("rst_tpg_en",    if_def.TPG_EN, 0);
    check_val("rst_busy_done", {if_def.busy, if_def.done, if_def.pass}, 0);
    check_val("rst_counts",    {if_def.err_count, if_def.pat_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // nominal session: start, 3 SETUP cycles, 10 RUN cycles
    start_s = 1'b1;
    step(1);
    start_s = 1'b0;
    check_val("t2_setup_busy", if_def.busy, 1);
    step(2);
    check_val("t2_setup_last_tpg_en", if_def.TPG_EN, 0);
    check_val("t2_setup_last_tpg_rst", if_def.TPG_RESET, 1);
    step(1);
    check_val("t2_run_tpg_en", {if_def.TPG_EN, if_def.ORA_EN, if_def.TPG_RESET}, 3'b110);
    for (int i = 0; i < 9; i++) run_cycle(1'b0, 1'b0);
    check_val("t2_pat_mid", if_def.pat_count, 9);
    check_val("t2_not_done", if_def.done, 0);
    run_cycle(1'b0, 1'b1);
    check_val("t2_done", {if_def.done, if_def.busy, if_def.TPG_EN}, 3'b100);
    check_val("t2_pat", if_def.pat_count, 10);
    check_val("t2_err", if_def.err_count, 0);
    check_val("t2_pass", if_def.pass, 1);
    // datapath inputs outside RUN are ignored
    run_cycle(1'b1, 1'b1);
    check_val("t2_ignore_cnt", {if_def.err_count, if_def.pat_count}, {8'd0, 16'd10});
    check_val("t2_ignore_done", if_def.done, 1);

    // two mismatches, last one with TPG_END; back-to-back start from DONE
    start_s = 1'b1;
    step(1);
    start_s = 1'b0;
    check_val("t3_cleared", {if_lim2.err_count, if_lim2.pat_count}, 0);
    step(3);
    run_cycle(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b1);
    check_val("t3_lim2_err", if_lim2.err_count, 2);
    check_val("t3_lim2_pat", if_lim2.pat_count, 6);
    check_val("t3_lim2_pass", {if_lim2.done, if_lim2.pass}, 2'b11);
    check_val("t3_lim1_pass", {if_lim1.done, if_lim1.pass}, 2'b10);
    check_val("t3_def_pass", if_def.pass, 0);

    // early stop on first error with STOP_ON_FAIL
    start_session();
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b0);
    check_val("t4_sof_done", if_sof.done, 1);
    check_val("t4_sof_cnt", {if_sof.err_count, if_sof.pat_count}, {8'd1, 16'd3});
    check_val("t4_sof_pass", if_sof.pass, 0);
    check_val("t4_def_still_run", if_def.busy, 1);
    run_cycle(1'b0, 1'b1);
    check_val("t4_sof_frozen", if_sof.pat_count, 3);

    // 2-bit error counter saturates
    start_session();
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
    check_val("t5_err3", if_sat.err_count, 3);
    run_cycle(1'b1, 1'b0);
    check_val("t5_err4_nowrap", if_sat.err_count, 3);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    check_val("t5_err6", if_sat.err_count, 3);
    run_cycle(1'b0, 1'b1);
    check_val("t5_done", {if_sat.done, if_sat.pass}, 2'b10);
    check_val("t5_pat", if_sat.pat_count, 7);
    check_val("t5_def_err", if_def.err_count, 6);

    // abort + start together mid-RUN
    start_session();
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b0, 1'b0);
    abort_s = 1'b1;
    start_s = 1'b1;
    step(1);
    abort_s = 1'b0;
    start_s = 1'b0;
    check_val("t6_idle", {if_def.busy, if_def.done, if_def.pass, if_def.TPG_RESET}, 4'b0001);
    check_val("t6_frozen", {if_def.err_count, if_def.pat_count}, {8'd1, 16'd3});
    step(2);
    check_val("t6_stay_idle", if_def.busy, 0);
    start_session();
    check_val("t6_restart_clr", if_def.pat_count, 0);
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b0, 1'b1);
    check_val("t6_done2", {if_def.done, if_def.pass, if_def.pat_count}, {2'b11, 16'd2});
    start_s = 1'b1;
    step(1);
    start_s = 1'b0;
    check_val("t6_done_restart", {if_def.busy, if_def.err_count, if_def.pat_count}, {1'b1, 8'd0, 16'd0});
    step(3);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0);
    run_cycle(1'b0, 1'b1);
    check_val("t6_sess3", {if_def.done, if_def.pass, if_def.pat_count}, {2'b11, 16'd4});

    // async reset mid-RUN
    start_session();
    run_cycle(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_val("t1_rst_out", {if_def.TPG_RESET, if_def.TPG_EN, if_def.ORA_EN, if_def.busy, if_def.done, if_def.pass}, 6'b100000);
    check_val("t1_rst_cnt", {if_def.err_count, if_def.pat_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    check_val("t1_idle_after", if_def.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
